inst_loader: RTL
================

# inst_loader

Boot-time instruction loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs each four bytes big-endian into a 32-bit word. It writes each word into instruction memory at consecutive word-aligned byte addresses. While a load is in progress it holds the core in reset through `cpu_rst`, and releases the core only after a complete, error-free load.

## Interface
- `WORDS`, 64: instruction-memory capacity in words; legal load length is 1..`WORDS`.
- `TIMEOUT`, 1024: maximum idle cycles allowed between accepted bytes during a load.
- `BOOT_HOLD`, 1: 1 = `cpu_rst` stays asserted from reset until the first successful load; 0 = `cpu_rst` deasserts on leaving reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load session; sampled only in IDLE or DONE.
- `len`  in  7  number of words to load; sampled with `start`.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  program byte; the first byte of each word goes to bits [31:24].
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  8  byte address of the write; always a multiple of 4.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_rst`  out  1  active-low reset to the core; 0 = core held in reset.
- `busy`  out  1  load in progress (RECV or WRITE state).
- `done`  out  1  sticky; last load completed successfully.
- `err`  out  1  sticky; last start was rejected or the last load timed out.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + `start`:
  - If `len` is 0 or greater than `WORDS`: set `err`=1, clear `done`, return to IDLE. `cpu_rst` is unchanged.
  - Otherwise: latch `len`, clear word index, byte count, timeout counter, `done` and `err`; drive `cpu_rst`=0; go to RECV.
- RECV:
  - `byte_ready`=1.
  - A byte is accepted on an edge where `byte_valid`&&`byte_ready`. It shifts into the word register (`w <= {w[23:0], byte_data}`), the byte count increments, and the timeout counter clears.
  - When the 4th byte is accepted, go to WRITE.
- WRITE:
  - One cycle. `imem_we`=1, `imem_addr`=word_index*4, `imem_wdata`=assembled word. `byte_ready`=0.
  - Next state: DONE if word_index==len-1, otherwise RECV with word_index+1 and byte count 0.
- DONE: `done`=1, `cpu_rst`=1, `byte_ready`=0.
- Timeout:
  - In RECV, the timeout counter increments on every cycle with no accepted byte.
  - When it reaches `TIMEOUT`-1 without an accept, the load aborts: `err`=1, state IDLE, `cpu_rst` stays 0. Partially written words remain in memory.
- `start` during RECV or WRITE is ignored.
- `byte_valid` outside RECV is ignored; no byte is consumed.
- `imem_addr` width rule: word_index is 6 bits and `imem_addr` = {word_index, 2'b00}. Address 0xFC is the last legal address for `WORDS`=64.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state IDLE; `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err`=0, all counters 0.
  - `cpu_rst`=0 if `BOOT_HOLD`=1, else 1.
- Reset asserted mid-load: the load is discarded immediately and all outputs take their reset values. No further `imem_we` pulse occurs.
- `byte_ready` rises the cycle after `start` is accepted.
- Each word costs at least 5 cycles: 4 accept cycles plus 1 WRITE cycle. `imem_we` asserts the cycle after the 4th accept.
- Last word:
  - `imem_we`=1 in cycle t.
  - `done`=1 and `cpu_rst`=1 in cycle t+1.
  - The core's first fetch therefore sees all words already written.
- `busy` equals (state==RECV || state==WRITE), registered.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset with `BOOT_HOLD`=1: `cpu_rst`=0, `byte_ready`=0, `done`=0, and all outputs at their reset values until a load completes.
- `start` with `len`=2, then bytes 20 08 00 05 8C 09 00 04 sent back-to-back:
  - `imem_we` pulses twice: addr 0x00 data 0x20080005, then addr 0x04 data 0x8C090004.
  - `done`=1 and `cpu_rst`=1 one cycle after the second pulse.
- Same load with `byte_valid` toggling 1-0-1-0: identical writes and no dropped bytes; `byte_ready`=0 during each WRITE cycle.
- `start` with `len`=0, and separately with `len`=65: `err`=1, state stays IDLE, no `imem_we`, `cpu_rst` unchanged.
- `len`=1, 2 bytes sent, then silence for `TIMEOUT` cycles: `err`=1, `busy`=0, `cpu_rst`=0, no `imem_we`. A following `start` clears `err` and the load succeeds.
- `len`=64 full load: the last write is at addr 0xFC. `rst` pulsed low after word 10 of a second load clears all state, and no further `imem_we` pulse occurs.

Source files
------------

// File: rtl/inst_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: one imem write one cycle after each 4th accepted byte; done/cpu_rst rise one cycle after the last write.
// Backpressure: byte_ready is high only in RECV (low during each WRITE cycle); idle gaps abort after TIMEOUT cycles.
module inst_loader #(
    parameter int WORDS     = 64,
    parameter int TIMEOUT   = 1024,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int             TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT - 1);
    localparam logic [7:0]     WORDS_L = 8'(WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [6:0]      len_q, len_nxt;
    logic [5:0]      idx, idx_nxt;
    logic [1:0]      bcnt, bcnt_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic [31:0]     w, w_nxt;
    logic            done_nxt, err_nxt, cpu_rst_nxt;
    logic            accept;
    logic            last_word;

    // byte_ready is a registered copy of (state == RECV), so this is the real handshake
    assign accept    = byte_valid & byte_ready;
    assign last_word = ({1'b0, idx} == (len_q - 7'd1));

    // Next-state and next-value logic for the load sequencer
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        idx_nxt     = idx;
        bcnt_nxt    = bcnt;
        tcnt_nxt    = tcnt;
        w_nxt       = w;
        done_nxt    = done;
        err_nxt     = err;
        cpu_rst_nxt = cpu_rst;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if ((len == 7'd0) || ({1'b0, len} > WORDS_L)) begin
                        // Rejected: leave the core's reset exactly as it was
                        err_nxt   = 1'b1;
                        done_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        len_nxt     = len;
                        idx_nxt     = 6'd0;
                        bcnt_nxt    = 2'd0;
                        tcnt_nxt    = '0;
                        done_nxt    = 1'b0;
                        err_nxt     = 1'b0;
                        cpu_rst_nxt = 1'b0;
                        state_nxt   = RECV;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    w_nxt    = {w[23:0], byte_data};
                    bcnt_nxt = bcnt + 2'd1;
                    tcnt_nxt = '0;
                    if (bcnt == 2'd3) begin
                        state_nxt = WRITE;
                    end
                end else if (tcnt == TMAX) begin
                    // Stalled sender: abort, keep the core in reset, leave partial words in memory
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            WRITE: begin
                if (last_word) begin
                    done_nxt    = 1'b1;
                    cpu_rst_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    idx_nxt   = idx + 6'd1;
                    bcnt_nxt  = 2'd0;
                    tcnt_nxt  = '0;
                    state_nxt = RECV;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state and internal counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            len_q <= 7'd0;
            idx   <= 6'd0;
            bcnt  <= 2'd0;
            tcnt  <= '0;
            w     <= 32'd0;
        end else begin
            state <= state_nxt;
            len_q <= len_nxt;
            idx   <= idx_nxt;
            bcnt  <= bcnt_nxt;
            tcnt  <= tcnt_nxt;
            w     <= w_nxt;
        end
    end

    // Registered outputs, computed from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 8'd0;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_rst    <= ~BOOT_HOLD;
        end else begin
            byte_ready <= (state_nxt == RECV);
            imem_we    <= (state_nxt == WRITE);
            busy       <= (state_nxt == RECV) || (state_nxt == WRITE);
            done       <= done_nxt;
            err        <= err_nxt;
            cpu_rst    <= cpu_rst_nxt;
            if (state_nxt == WRITE) begin
                imem_addr  <= {idx_nxt, 2'b00};
                imem_wdata <= w_nxt;
            end
        end
    end

endmodule
